// File: rtl/encoder_event.sv
// Sequential 8-to-3 event encoder: rising edges on request lines are queued and
// served highest-index first through a valid/acknowledge handshake.
//
// state   | meaning
// IDLE    | no code presented; loads the highest pending index when enabled
// PRESENT | oData/oValid held until the consumer acknowledges
module encoder_event #(
    parameter int N  = 8,
    parameter int CW = 3
) (
    input  logic          iClk,
    input  logic          iRst_n,
    input  logic [N-1:0]  iData,
    input  logic [1:0]    iEna,
    input  logic          iAck,
    output logic [CW-1:0] oData,
    output logic          oValid,
    output logic          oOverrun,
    output logic [N-1:0]  oPending
);

    localparam logic [0:0] IDLE    = 1'b0;
    localparam logic [0:0] PRESENT = 1'b1;

    logic [0:0]    state;
    logic [N-1:0]  prevData;
    logic [N-1:0]  pending;
    logic [N-1:0]  rise;
    logic [N-1:0]  clr;
    logic [CW-1:0] hiIdx;
    logic          enabled;
    logic          loadNow;

    assign enabled  = (iEna == 2'b10);
    assign rise     = iData & ~prevData;
    assign loadNow  = (state == IDLE) && (pending != '0);
    assign oPending = pending;

    // Ascending scan so the last hit, the highest index, wins.
    always_comb begin
        hiIdx = '0;
        for (int i = 0; i < N; i++) begin
            if (pending[i]) hiIdx = CW'(i);
        end
    end

    assign clr = loadNow ? (N'(1) << hiIdx) : '0;

    // prevData keeps tracking during reset and disable so static-high lines never fire.
    always_ff @(posedge iClk) begin
        prevData <= iData;
        if (!iRst_n) begin
            state    <= IDLE;
            pending  <= '0;
            oData    <= '0;
            oValid   <= 1'b0;
            oOverrun <= 1'b0;
        end else if (!enabled) begin
            state    <= IDLE;
            pending  <= '0;
            oValid   <= 1'b0;
            oOverrun <= 1'b0;
        end else begin
            pending <= (pending & ~clr) | rise;
            if ((rise & pending & ~clr) != '0) oOverrun <= 1'b1;
            case (state)
                IDLE: begin
                    if (loadNow) begin
                        oData  <= hiIdx;
                        oValid <= 1'b1;
                        state  <= PRESENT;
                    end
                end
                PRESENT: begin
                    if (iAck) begin
                        oValid <= 1'b0;
                        state  <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_encoder_event.sv
// Directed bench for encoder_event: expected codes are queued as edges are driven
// and popped by a monitor whenever a new code is presented.
module tb_encoder_event;

    logic       iClk = 1'b0;
    logic       iRst_n;
    logic [7:0] iData;
    logic [1:0] iEna;
    logic       iAck;
    logic [2:0] oData;
    logic       oValid;
    logic       oOverrun;
    logic [7:0] oPending;

    int errors = 0;
    int checks = 0;
    logic [2:0] expQ[$];
    logic       lastValid = 1'b0;
    logic [2:0] heldData;

    encoder_event #(.N(8), .CW(3)) dut (
        .iClk(iClk), .iRst_n(iRst_n), .iData(iData), .iEna(iEna), .iAck(iAck),
        .oData(oData), .oValid(oValid), .oOverrun(oOverrun), .oPending(oPending)
    );

    always #5 iClk = ~iClk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge iClk);
        #1;
    endtask

    // Scoreboard: each rising oValid must match the oldest queued code.
    always @(negedge iClk) begin
        if (oValid && !lastValid) begin
            checks++;
            assert (expQ.size() != 0) else begin
                errors++;
                $error("FAIL spurious_code: observed=%0d expected=none", oData);
            end
            if (expQ.size() != 0) check("code_order", 32'(oData), 32'(expQ.pop_front()));
        end
        lastValid <= oValid;
    end

    initial begin
        #200000;
        errors++;
        $display("FAIL timeout: observed=running expected=finished");
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $fatal(1, "timeout");
    end

    initial begin
        iRst_n = 1'b0; iData = 8'hFF; iEna = 2'b10; iAck = 1'b0;
        repeat (3) step();
        check("rst_valid", 32'(oValid), 0);
        check("rst_data", 32'(oData), 0);
        check("rst_pending", 32'(oPending), 0);
        check("rst_overrun", 32'(oOverrun), 0);

        // Lines already high at release must not fire.
        iRst_n = 1'b1;
        for (int i = 0; i < 10; i++) begin
            step();
            check("hold_valid", 32'(oValid), 0);
            check("hold_pending", 32'(oPending), 0);
        end

        // Single event on bit 5.
        iData = 8'h00; step();
        iData = 8'h20; expQ.push_back(3'd5);
        step();
        check("single_pend", 32'(oPending), 32'h20);
        check("single_early", 32'(oValid), 0);
        step();
        check("single_valid", 32'(oValid), 1);
        check("single_data", 32'(oData), 5);
        check("single_clr", 32'(oPending), 0);
        iAck = 1'b1; step(); iAck = 1'b0;
        check("single_ack", 32'(oValid), 0);
        step();
        check("single_idle", 32'(oValid), 0);

        // Priority: bits 1, 3, 6 together with iAck held high.
        iData = 8'h6A; iAck = 1'b1;
        expQ.push_back(3'd6); expQ.push_back(3'd3); expQ.push_back(3'd1);
        step();
        check("prio_pend", 32'(oPending), 32'h4A);
        check("prio_v0", 32'(oValid), 0);
        step(); check("prio_v1", 32'(oValid), 1); check("prio_d6", 32'(oData), 6);
        check("prio_pend2", 32'(oPending), 32'h0A);
        step(); check("prio_gap1", 32'(oValid), 0);
        step(); check("prio_v3", 32'(oValid), 1); check("prio_d3", 32'(oData), 3);
        step(); check("prio_gap2", 32'(oValid), 0);
        step(); check("prio_v5", 32'(oValid), 1); check("prio_d1", 32'(oData), 1);
        step(); check("prio_gap3", 32'(oValid), 0);
        check("prio_empty", 32'(oPending), 0);
        check("prio_ovr", 32'(oOverrun), 0);
        iAck = 1'b0;

        // Re-queue of the bit being presented.
        iData = 8'h7A; expQ.push_back(3'd4);
        step(); check("rq_pend", 32'(oPending), 32'h10);
        step(); check("rq_valid", 32'(oValid), 1); check("rq_data", 32'(oData), 4);
        check("rq_clr", 32'(oPending), 0);
        iData = 8'h6A; step();
        iData = 8'h7A; expQ.push_back(3'd4);
        step();
        check("rq_repend", 32'(oPending), 32'h10);
        check("rq_hold", 32'(oValid), 1);
        check("rq_ovr", 32'(oOverrun), 0);
        iAck = 1'b1; step(); iAck = 1'b0;
        check("rq_ack", 32'(oValid), 0);
        step();
        check("rq_again", 32'(oValid), 1); check("rq_again_d", 32'(oData), 4);
        check("rq_ovr2", 32'(oOverrun), 0);
        iAck = 1'b1; step(); iAck = 1'b0;

        // Overrun: bit 2 fires twice while 7 is presented.
        iData = 8'hFA; expQ.push_back(3'd7);
        step(); step();
        check("ovr_v7", 32'(oValid), 1); check("ovr_d7", 32'(oData), 7);
        iData = 8'hFE; step();
        check("ovr_pend", 32'(oPending), 32'h04);
        check("ovr_first", 32'(oOverrun), 0);
        iData = 8'hFA; step();
        iData = 8'hFE; expQ.push_back(3'd2);
        step();
        check("ovr_set", 32'(oOverrun), 1);
        check("ovr_pend2", 32'(oPending), 32'h04);
        check("ovr_still7", 32'(oData), 7);
        iAck = 1'b1;
        step(); check("ovr_ack7", 32'(oValid), 0);
        step(); check("ovr_v2", 32'(oValid), 1); check("ovr_d2", 32'(oData), 2);
        step(); check("ovr_ack2", 32'(oValid), 0);
        iAck = 1'b0;
        repeat (4) step();
        check("ovr_once", 32'(oValid), 0);
        check("ovr_sticky", 32'(oOverrun), 1);

        // Disable mid-transaction with pending = 8'h09.
        iData = 8'hB6; step();
        iData = 8'hFF; expQ.push_back(3'd6);
        step(); check("dis_pend0", 32'(oPending), 32'h49);
        step();
        check("dis_valid", 32'(oValid), 1);
        check("dis_pend", 32'(oPending), 32'h09);
        heldData = 3'd6;
        iEna = 2'b11; step();
        check("dis_v", 32'(oValid), 0);
        check("dis_p", 32'(oPending), 0);
        check("dis_o", 32'(oOverrun), 0);
        check("dis_d", 32'(oData), 32'(heldData));
        iEna = 2'b10;
        for (int i = 0; i < 6; i++) begin
            step();
            check("reen_valid", 32'(oValid), 0);
            check("reen_pend", 32'(oPending), 0);
        end
        check("queue_drained", 32'(expQ.size()), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
